// File: rtl/ram_arbiter.sv
// Two-port arbiter for the shared single-port program/data RAM.
// CPU data port and VGA character fetch share one RAM; video may claim absolute priority.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access; requests sampled, owner chosen and latched
// ISSUE | address (and write data / write strobe) presented to the RAM
// WAIT  | read latency countdown; ram_dout captured on the last cycle
// DONE  | owner ack pulse; RAM buses back to zero
module ram_arbiter #(
  parameter int RD_LAT = 1,
  parameter int AW     = 16,
  parameter int DW     = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          vid_req,
  input  logic          vid_urgent,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          grant_vid
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state;
  logic [2:0] wait_cnt;
  logic       op_we;
  logic       op_vid;
  logic       last_vid;
  logic       pick_vid;

  // Urgent video first, then a lone requester, then alternate on a tie.
  always_comb begin
    pick_vid = 1'b0;
    if (vid_req && vid_urgent)
      pick_vid = 1'b1;
    else if (vid_req != cpu_req)
      pick_vid = vid_req;
    else
      pick_vid = ~last_vid;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      op_we     <= 1'b0;
      op_vid    <= 1'b0;
      last_vid  <= 1'b1;
      cpu_ack   <= 1'b0;
      vid_ack   <= 1'b0;
      cpu_rdata <= '0;
      vid_rdata <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we    <= 1'b0;
      busy      <= 1'b0;
      grant_vid <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || vid_req) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            op_vid    <= pick_vid;
            last_vid  <= pick_vid;
            grant_vid <= pick_vid;
            op_we     <= ~pick_vid & cpu_we;
            ram_we    <= ~pick_vid & cpu_we;
            ram_addr  <= pick_vid ? vid_addr : cpu_addr;
            ram_din   <= (!pick_vid && cpu_we) ? cpu_wdata : '0;
          end
        end
        ISSUE: begin
          ram_we  <= 1'b0;
          ram_din <= '0;
          if (op_we) begin
            state    <= DONE;
            ram_addr <= '0;
            cpu_ack  <= ~op_vid;
            vid_ack  <= op_vid;
          end else begin
            state    <= WAIT;
            wait_cnt <= 3'(RD_LAT - 1);
          end
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            if (op_vid)
              vid_rdata <= ram_dout;
            else
              cpu_rdata <= ram_dout;
            state    <= DONE;
            ram_addr <= '0;
            cpu_ack  <= ~op_vid;
            vid_ack  <= op_vid;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (read latency 1 and 3), each with its own RAM model.
// Directed scenarios plus a randomized run against a cycle-timing reference model.
module tb_ram_arbiter;

  localparam int RDL [2] = '{1, 3};

  logic clock = 1'b0;
  logic rst_n;
  always #20 clock = ~clock;

  logic        cpu_req [2];
  logic        cpu_we [2];
  logic [15:0] cpu_addr [2];
  logic [15:0] cpu_wdata [2];
  logic        cpu_ack [2];
  logic [15:0] cpu_rdata [2];
  logic        vid_req [2];
  logic        vid_urgent [2];
  logic [15:0] vid_addr [2];
  logic        vid_ack [2];
  logic [15:0] vid_rdata [2];
  logic [15:0] ram_addr [2];
  logic [15:0] ram_din [2];
  logic        ram_we [2];
  logic [15:0] ram_dout [2];
  logic        busy [2];
  logic        grant_vid [2];

  int total = 0;
  int bad = 0;

  ram_arbiter #(.RD_LAT(1), .AW(16), .DW(16)) dut1 (
    .clock(clock), .reset(rst_n),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]),
    .vid_req(vid_req[0]), .vid_urgent(vid_urgent[0]), .vid_addr(vid_addr[0]),
    .vid_ack(vid_ack[0]), .vid_rdata(vid_rdata[0]),
    .ram_addr(ram_addr[0]), .ram_din(ram_din[0]), .ram_we(ram_we[0]), .ram_dout(ram_dout[0]),
    .busy(busy[0]), .grant_vid(grant_vid[0])
  );

  ram_arbiter #(.RD_LAT(3), .AW(16), .DW(16)) dut3 (
    .clock(clock), .reset(rst_n),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]),
    .vid_req(vid_req[1]), .vid_urgent(vid_urgent[1]), .vid_addr(vid_addr[1]),
    .vid_ack(vid_ack[1]), .vid_rdata(vid_rdata[1]),
    .ram_addr(ram_addr[1]), .ram_din(ram_din[1]), .ram_we(ram_we[1]), .ram_dout(ram_dout[1]),
    .busy(busy[1]), .grant_vid(grant_vid[1])
  );

  // RAM models: unwritten words read back as addr ^ 16'h5A5A; dout follows the issued
  // address after exactly RD_LAT cycles.
  logic [15:0] mem [2][65536];
  bit          wr  [2][65536];
  logic [15:0] apipe [2][8];
  int          we_cnt [2];

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_we[d]) begin
        mem[d][ram_addr[d]] <= ram_din[d];
        wr[d][ram_addr[d]]  <= 1'b1;
        we_cnt[d]           <= we_cnt[d] + 1;
      end
      apipe[d][0] <= ram_addr[d];
      for (int k = 1; k < 8; k++) apipe[d][k] <= apipe[d][k-1];
    end
  end

  assign ram_dout[0] = wr[0][apipe[0][0]] ? mem[0][apipe[0][0]] : (apipe[0][0] ^ 16'h5A5A);
  assign ram_dout[1] = wr[1][apipe[1][2]] ? mem[1][apipe[1][2]] : (apipe[1][2] ^ 16'h5A5A);

  logic [15:0] mmem [int];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      cpu_req[d] = 0; cpu_we[d] = 0; cpu_addr[d] = '0; cpu_wdata[d] = '0;
      vid_req[d] = 0; vid_urgent[d] = 0; vid_addr[d] = '0;
    end
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_cpu_ack(input int d, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!cpu_ack[d] && lat < 40);
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 20 && busy[d]; i++) tick();
  endtask

  task automatic test_reset();
    logic [68:0] got;
    clear_inputs();
    rst_n = 1'b0;
    #10;
    for (int d = 0; d < 2; d++) begin
      got = {cpu_ack[d], vid_ack[d], ram_we[d], busy[d], grant_vid[d],
             cpu_rdata[d], vid_rdata[d], ram_addr[d], ram_din[d]};
      total++;
      if (got !== 69'd0) begin
        bad++; $display("FAIL reset_outputs d%0d got=%h want=0", d, got);
      end
    end
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (busy[d] !== 1'b0) begin
        bad++; $display("FAIL reset_idle d%0d busy got=%b want=0", d, busy[d]);
      end
    end
  endtask

  task automatic test_cpu_write();
    int w0;
    for (int d = 0; d < 2; d++) begin
      w0 = we_cnt[d];
      cpu_req[d] = 1; cpu_we[d] = 1; cpu_addr[d] = 16'h0010; cpu_wdata[d] = 16'hBEEF;
      tick();
      total++;
      if ({ram_we[d], ram_addr[d], ram_din[d], cpu_ack[d], grant_vid[d], busy[d]} !==
          {1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 1'b1}) begin
        bad++; $display("FAIL wr_issue d%0d got we=%b a=%h d=%h ack=%b gv=%b busy=%b want 1 0010 beef 0 0 1",
                        d, ram_we[d], ram_addr[d], ram_din[d], cpu_ack[d], grant_vid[d], busy[d]);
      end
      tick();
      total++;
      if (cpu_ack[d] !== 1'b1) begin
        bad++; $display("FAIL wr_ack_T2 d%0d got=%b want=1", d, cpu_ack[d]);
      end
      total++;
      if ({ram_we[d], ram_addr[d], ram_din[d]} !== 33'd0) begin
        bad++; $display("FAIL wr_done_bus d%0d got we=%b a=%h d=%h want 0", d, ram_we[d], ram_addr[d], ram_din[d]);
      end
      cpu_req[d] = 0;
      tick();
      total++;
      if ({cpu_ack[d], busy[d]} !== 2'b00) begin
        bad++; $display("FAIL wr_after d%0d got ack=%b busy=%b want 0 0", d, cpu_ack[d], busy[d]);
      end
      total++;
      if (we_cnt[d] - w0 != 1) begin
        bad++; $display("FAIL wr_pulse_count d%0d got=%0d want=1", d, we_cnt[d] - w0);
      end
    end
  endtask

  task automatic test_cpu_read();
    int lat;
    for (int d = 0; d < 2; d++) begin
      cpu_req[d] = 1; cpu_we[d] = 0; cpu_addr[d] = 16'h0010;
      wait_cpu_ack(d, lat);
      total++;
      if (lat != 2 + RDL[d]) begin
        bad++; $display("FAIL rd_latency d%0d got=%0d want=%0d", d, lat, 2 + RDL[d]);
      end
      total++;
      if (cpu_rdata[d] !== 16'hBEEF) begin
        bad++; $display("FAIL rd_data d%0d got=%h want=beef", d, cpu_rdata[d]);
      end
      total++;
      if (vid_rdata[d] !== 16'h0000) begin
        bad++; $display("FAIL rd_vid_untouched d%0d got=%h want=0000", d, vid_rdata[d]);
      end
      cpu_req[d] = 0;
      tick();
      total++;
      if ({cpu_ack[d], cpu_rdata[d]} !== {1'b0, 16'hBEEF}) begin
        bad++; $display("FAIL rd_hold d%0d got ack=%b d=%h want 0 beef", d, cpu_ack[d], cpu_rdata[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int w0;
    for (int d = 0; d < 2; d++) begin
      w0 = we_cnt[d];
      cpu_req[d] = 1; cpu_we[d] = 1; cpu_addr[d] = 16'h00FF; cpu_wdata[d] = 16'h1234;
      wait_cpu_ack(d, lat);
      total++;
      if (lat != 2) begin
        bad++; $display("FAIL b2b_wr_latency d%0d got=%0d want=2", d, lat);
      end
      cpu_we[d] = 0;
      tick();
      total++;
      if ({busy[d], cpu_ack[d], ram_we[d]} !== 3'b000) begin
        bad++; $display("FAIL b2b_idle_gap d%0d got busy=%b ack=%b we=%b want 0 0 0", d, busy[d], cpu_ack[d], ram_we[d]);
      end
      tick();
      total++;
      if ({busy[d], ram_we[d], ram_addr[d]} !== {1'b1, 1'b0, 16'h00FF}) begin
        bad++; $display("FAIL b2b_rd_issue d%0d got busy=%b we=%b a=%h want 1 0 00ff", d, busy[d], ram_we[d], ram_addr[d]);
      end
      wait_cpu_ack(d, lat);
      total++;
      if (lat != 1 + RDL[d]) begin
        bad++; $display("FAIL b2b_rd_latency d%0d got=%0d want=%0d", d, lat, 1 + RDL[d]);
      end
      total++;
      if (cpu_rdata[d] !== 16'h1234) begin
        bad++; $display("FAIL b2b_rd_data d%0d got=%h want=1234", d, cpu_rdata[d]);
      end
      total++;
      if (we_cnt[d] - w0 != 1) begin
        bad++; $display("FAIL b2b_pulse_count d%0d got=%0d want=1", d, we_cnt[d] - w0);
      end
      cpu_req[d] = 0;
      tick();
    end
  endtask

  task automatic test_round_robin();
    int n, cyc, overlap;
    logic pb;
    bit gv [4];
    logic [15:0] ga [4];
    apply_reset();
    for (int d = 0; d < 2; d++) begin
      n = 0; cyc = 0; overlap = 0; pb = 1'b0;
      cpu_req[d] = 1; cpu_we[d] = 0; cpu_addr[d] = 16'h0001;
      vid_req[d] = 1; vid_urgent[d] = 0; vid_addr[d] = 16'h2000;
      while (n < 4 && cyc < 100) begin
        tick();
        cyc++;
        if (cpu_ack[d] && vid_ack[d]) overlap++;
        if (cpu_ack[d]) begin
          total++;
          if (cpu_rdata[d] !== 16'h5A5B) begin
            bad++; $display("FAIL rr_cpu_data d%0d got=%h want=5a5b", d, cpu_rdata[d]);
          end
        end
        if (vid_ack[d]) begin
          total++;
          if (vid_rdata[d] !== 16'h7A5A) begin
            bad++; $display("FAIL rr_vid_data d%0d got=%h want=7a5a", d, vid_rdata[d]);
          end
        end
        if (busy[d] && !pb) begin
          gv[n] = grant_vid[d];
          ga[n] = ram_addr[d];
          n++;
        end
        pb = busy[d];
      end
      cpu_req[d] = 0; vid_req[d] = 0;
      for (int i = 0; i < 20 && busy[d]; i++) begin
        tick();
        if (cpu_ack[d] && vid_ack[d]) overlap++;
      end
      total++;
      if (n != 4) begin
        bad++; $display("FAIL rr_grant_count d%0d got=%0d want=4", d, n);
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if ({gv[i], ga[i]} !== {(i % 2 == 1), ((i % 2 == 1) ? 16'h2000 : 16'h0001)}) begin
          bad++; $display("FAIL rr_grant%0d d%0d got gv=%b a=%h want gv=%0d", i, d, gv[i], ga[i], i % 2);
        end
      end
      total++;
      if (overlap != 0) begin
        bad++; $display("FAIL rr_ack_overlap d%0d got=%0d want=0", d, overlap);
      end
    end
  endtask

  task automatic test_urgent();
    int n, cyc, overlap;
    logic pb;
    bit gv [5];
    bit want [5];
    want = '{0, 1, 1, 1, 0};
    apply_reset();
    for (int d = 0; d < 2; d++) begin
      n = 0; cyc = 0; overlap = 0; pb = 1'b0;
      cpu_req[d] = 1; cpu_we[d] = 0; cpu_addr[d] = 16'h0003; vid_addr[d] = 16'h2004;
      while (n < 5 && cyc < 200) begin
        tick();
        cyc++;
        if (cpu_ack[d] && vid_ack[d]) overlap++;
        if (busy[d] && !pb) begin
          gv[n] = grant_vid[d];
          n++;
          if (n == 1) begin vid_req[d] = 1; vid_urgent[d] = 1; end
          if (n == 4) vid_urgent[d] = 0;
        end
        pb = busy[d];
      end
      cpu_req[d] = 0; vid_req[d] = 0; vid_urgent[d] = 0;
      drain(d);
      total++;
      if (n != 5) begin
        bad++; $display("FAIL urg_grant_count d%0d got=%0d want=5", d, n);
      end
      for (int i = 0; i < 5; i++) begin
        total++;
        if (gv[i] !== want[i]) begin
          bad++; $display("FAIL urg_grant%0d d%0d got=%b want=%b", i, d, gv[i], want[i]);
        end
      end
      total++;
      if (overlap != 0) begin
        bad++; $display("FAIL urg_ack_overlap d%0d got=%0d want=0", d, overlap);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int w0, acks, cyc, lat;
    logic [68:0] got;
    w0 = we_cnt[1];
    acks = 0;
    cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 16'h0010;
    tick();
    tick();
    total++;
    if (busy[1] !== 1'b1) begin
      bad++; $display("FAIL mid_in_wait busy got=%b want=1", busy[1]);
    end
    #5;
    rst_n = 1'b0;
    #1;
    got = {cpu_ack[1], vid_ack[1], ram_we[1], busy[1], grant_vid[1],
           cpu_rdata[1], vid_rdata[1], ram_addr[1], ram_din[1]};
    total++;
    if (got !== 69'd0) begin
      bad++; $display("FAIL mid_reset_outputs got=%h want=0", got);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_ack[1] || vid_ack[1] || ram_we[1]) acks++;
    end
    vid_req[1] = 1; vid_urgent[1] = 0; vid_addr[1] = 16'h2000;
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    while (!busy[1] && cyc < 20) begin
      tick();
      cyc++;
    end
    total++;
    if ({busy[1], grant_vid[1], ram_addr[1]} !== {1'b1, 1'b0, 16'h0010}) begin
      bad++; $display("FAIL mid_tie_after_reset got busy=%b gv=%b a=%h want 1 0 0010", busy[1], grant_vid[1], ram_addr[1]);
    end
    lat = 0;
    while (!cpu_ack[1] && lat < 20) begin
      tick();
      lat++;
    end
    total++;
    if ({cpu_ack[1], cpu_rdata[1]} !== {1'b1, 16'hBEEF}) begin
      bad++; $display("FAIL mid_reread got ack=%b d=%h want 1 beef", cpu_ack[1], cpu_rdata[1]);
    end
    total++;
    if (acks != 0 || we_cnt[1] != w0) begin
      bad++; $display("FAIL mid_no_ack got acks=%0d we_pulses=%0d want 0 0", acks, we_cnt[1] - w0);
    end
    clear_inputs();
    tick();
    drain(1);
  endtask

  task automatic test_random(input int d);
    int iss, ackc;
    bit cv, cw, last, gnt;
    bit e_busy, e_we, e_cack, e_vack, in_bus;
    bit pcr, pcw, pvr, pvu;
    logic [15:0] ca, cwd, erc, erv, pca, pcd, pva;
    logic [20:0] got, want;
    iss = -100; ackc = -100;
    cv = 0; cw = 0; last = 1; gnt = 0;
    ca = '0; cwd = '0; erc = '0; erv = '0;
    pcr = 0; pcw = 0; pvr = 0; pvu = 0; pca = '0; pcd = '0; pva = '0;
    mmem.delete();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      tick();
      // An access may start only if the previous cycle was idle and someone was asking.
      if (c - 1 > ackc && (pcr || pvr)) begin
        if (pvr && pvu) cv = 1;
        else if (pvr && !pcr) cv = 1;
        else if (pcr && !pvr) cv = 0;
        else cv = ~last;
        cw = cv ? 1'b0 : pcw;
        ca = cv ? pva : pca;
        cwd = pcd;
        iss = c;
        ackc = cw ? c + 1 : c + 1 + RDL[d];
        last = cv;
        gnt = cv;
      end
      if (c == ackc) begin
        if (cw) mmem[int'(ca)] = cwd;
        else if (cv) erv = mmem.exists(int'(ca)) ? mmem[int'(ca)] : (ca ^ 16'h5A5A);
        else erc = mmem.exists(int'(ca)) ? mmem[int'(ca)] : (ca ^ 16'h5A5A);
      end
      e_busy = (c >= iss) && (c <= ackc);
      in_bus = (c >= iss) && (c < ackc);
      e_we = cw && (c == iss);
      e_cack = (c == ackc) && !cv;
      e_vack = (c == ackc) && cv;
      got  = {busy[d], ram_we[d], cpu_ack[d], vid_ack[d], grant_vid[d], ram_addr[d]};
      want = {e_busy, e_we, e_cack, e_vack, gnt, in_bus ? ca : 16'h0000};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL rnd_ctl d%0d cyc=%0d got=%h want=%h", d, c, got, want);
      end
      total++;
      if ({cpu_rdata[d], vid_rdata[d]} !== {erc, erv}) begin
        bad++; $display("FAIL rnd_rdata d%0d cyc=%0d got=%h/%h want=%h/%h", d, c, cpu_rdata[d], vid_rdata[d], erc, erv);
      end
      if (e_we || !in_bus) begin
        total++;
        if (ram_din[d] !== (e_we ? cwd : 16'h0000)) begin
          bad++; $display("FAIL rnd_din d%0d cyc=%0d got=%h want=%h", d, c, ram_din[d], e_we ? cwd : 16'h0000);
        end
      end
      if (cpu_req[d]) begin
        if (e_cack) begin
          if ($urandom_range(0, 1) == 0) cpu_req[d] = 0;
          else begin
            cpu_we[d] = 1'($urandom_range(0, 1));
            cpu_addr[d] = 16'h0100 + 16'($urandom_range(0, 7));
            cpu_wdata[d] = 16'($urandom);
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        cpu_req[d] = 1;
        cpu_we[d] = 1'($urandom_range(0, 1));
        cpu_addr[d] = 16'h0100 + 16'($urandom_range(0, 7));
        cpu_wdata[d] = 16'($urandom);
      end
      if (vid_req[d]) begin
        if (e_vack) begin
          if ($urandom_range(0, 1) == 0) vid_req[d] = 0;
          else vid_addr[d] = 16'h0100 + 16'($urandom_range(0, 7));
        end
      end else if ($urandom_range(0, 2) == 0) begin
        vid_req[d] = 1;
        vid_addr[d] = 16'h0100 + 16'($urandom_range(0, 7));
      end
      vid_urgent[d] = ($urandom_range(0, 3) == 0);
      pcr = cpu_req[d]; pcw = cpu_we[d]; pca = cpu_addr[d]; pcd = cpu_wdata[d];
      pvr = vid_req[d]; pvu = vid_urgent[d]; pva = vid_addr[d];
    end
    clear_inputs();
    tick();
    drain(d);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_back_to_back();
    test_round_robin();
    test_urgent();
    test_reset_mid_read();
    test_random(0);
    test_random(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 16-bit program/data RAM between two requesters: the CPU data port and the VGA character-fetch port.
- Arbitrates between them, sequences each access (issue, read-latency wait, acknowledge) and returns read data to the granted requester.
- Sits between the processor/video logic and the RAM address/data/RW buses inside the kit top level.
- Runs on the 25 MHz system clock.

Parameters:
- RD_LAT, 1, RAM read latency in cycles from the address issue to valid ram_dout (legal 1..7).
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1=write, 0=read; stable while cpu_req is high.
- cpu_addr  in  AW  CPU address; stable while cpu_req is high.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DW  read data; valid while cpu_ack=1; held until the next CPU read completes.
- vid_req  in  1  video read request; held until vid_ack.
- vid_urgent  in  1  video line-buffer low; gives absolute priority.
- vid_addr  in  AW  video character address.
- vid_ack  out  1  one-cycle completion pulse.
- vid_rdata  out  DW  character word; valid while vid_ack=1; held until the next video completion.
- ram_addr  out  AW  RAM address bus.
- ram_din  out  DW  RAM write data.
- ram_we  out  1  RAM RW strobe; 1=write.
- ram_dout  in  DW  RAM read data.
- busy  out  1  high in any state other than IDLE.
- grant_vid  out  1  owner of the current or last access; 1=video.

Behaviour:
- Reset (async, reset=0) clears all of the following, immediately and regardless of state:
  - All outputs go to 0; state goes to IDLE; the last-owner flag goes to video, so CPU wins the first tie.
  - An in-flight access is abandoned: no ack is issued, and no further ram_we pulse is produced.
- State machine: IDLE -> ISSUE -> [WAIT x RD_LAT, reads only] -> DONE -> IDLE.
- IDLE:
  - Samples the requests; if any is pending, chooses the owner and goes to ISSUE on the next edge.
  - Latches the owner's addr, we and wdata at that edge.
- Owner selection:
  - If vid_req and vid_urgent are both high, video wins.
  - Otherwise, if only one request is high, that requester wins.
  - Otherwise (both high), strict round-robin: the requester that was not the last owner wins.
- ISSUE (1 cycle):
  - ram_addr is the latched address.
  - For a write: ram_we=1 and ram_din is the write data; the next state is DONE.
  - For a read: ram_we=0; the next state is WAIT.
- WAIT:
  - A 3-bit counter runs for RD_LAT cycles; ram_addr is held.
  - On the final WAIT cycle, ram_dout is captured into the owner's rdata register.
- DONE (1 cycle): the owner's ack is 1; ram_addr, ram_din and ram_we return to 0; the next state is IDLE.
- Latency from request to ack, when the request is sampled in IDLE at cycle T:
  - Write: ack in cycle T+2.
  - Read: ack in cycle T+2+RD_LAT.
- Between ack and the next grant there is at least one IDLE cycle.
- ram_we is high only in ISSUE of a write, for exactly one cycle per write.
- In IDLE and DONE, ram_addr and ram_din are 0.
- Requester rule: a requester drops req in the cycle after its ack. If req is still high in the IDLE cycle that follows, it is treated as a new access.
- Request changes outside IDLE are ignored. A req that rises and falls while busy is lost, which is a protocol violation and is not checked.
- Read data path: cpu_rdata and vid_rdata are written only on their owner's read capture. Writes never modify either register.
- At most one ack is high in any cycle; acks never overlap.
- grant_vid updates at the IDLE->ISSUE edge and holds until the next grant.

Test Plan:
- Single CPU write: addr=0x0010, wdata=0xBEEF.
  - Expect ram_we=1 for exactly 1 cycle with ram_addr=0x0010 and ram_din=0xBEEF.
  - Expect cpu_ack at T+2.
- CPU read, RD_LAT=1 and RD_LAT=3: the RAM model returns 0xBEEF for 0x0010.
  - Expect cpu_rdata=0xBEEF with cpu_ack at T+3 and T+5 respectively.
  - Expect vid_rdata to be unchanged.
- Simultaneous persistent requests after reset, vid_urgent=0: CPU reads 0x0001, video reads 0x2000, both re-requesting continuously.
  - Expect grant order CPU, VID, CPU, VID.
  - Expect acks never overlapping, and ram_addr alternating 0x0001 / 0x2000.
- Urgent video: CPU wins one access, then both requests are held with vid_urgent=1 for three accesses.
  - Expect three consecutive video grants.
  - After vid_urgent drops, expect the CPU to be granted next.
- Reset mid-read: assert reset during WAIT with RD_LAT=3.
  - Expect all outputs 0 immediately and no ack.
  - Expect busy=0 and grant_vid=0.
  - After release, expect CPU to win the tie.
- Back-to-back CPU write then read of the same address 0x00FF with data 0x1234.
  - Expect the read to return 0x1234 and one IDLE cycle between the two accesses.
